// File: rtl/conv_stream_controller.sv
// Byte-stream loader/unloader for the 3x3 systolic convolution array.
// Ports: s_* byte in, i_mat/f_mat/arr_clr to array, o_mat from array, m_* byte out, busy.
module conv_stream_controller #(
  parameter int DATA_W         = 8,
  parameter int COMPUTE_CYCLES = 20,
  parameter int CNT_W          = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [16*DATA_W-1:0]  i_mat,
  output logic [9*DATA_W-1:0]   f_mat,
  output logic                  arr_clr,
  input  logic [4*DATA_W-1:0]   o_mat,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    LOAD,
    CLEAR,
    COMPUTE,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [4:0]          n;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          k;
  logic [4*DATA_W-1:0] res;
  logic                m_valid_q;

  logic s_fire;
  logic m_fire;
  logic last_byte;
  logic cap;

  assign s_ready   = (state == LOAD) & rst;
  assign arr_clr   = (state == CLEAR);
  assign busy      = (state != LOAD);
  assign m_valid   = m_valid_q;
  assign m_data    = m_valid_q ? res[k*DATA_W +: DATA_W] : '0;

  assign s_fire    = s_valid & s_ready;
  assign m_fire    = m_valid_q & m_ready;
  assign last_byte = (n == 5'd24);
  assign cap       = (cnt == CNT_W'(COMPUTE_CYCLES - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (s_fire && last_byte) state_nx = CLEAR;
      CLEAR:   state_nx = COMPUTE;
      COMPUTE: if (cap) state_nx = DRAIN;
      DRAIN:   if (m_fire && k == 2'd3) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end

  // m_valid rises one cycle after capture so the latched
  // result is stable before it is offered downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n         <= '0;
      cnt       <= '0;
      k         <= '0;
      res       <= '0;
      m_valid_q <= 1'b0;
      i_mat     <= '0;
      f_mat     <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (s_fire) begin
            if (n < 5'd16)
              i_mat[n*DATA_W +: DATA_W] <= s_data;
            else
              f_mat[(n-16)*DATA_W +: DATA_W] <= s_data;
            n <= last_byte ? 5'd0 : n + 5'd1;
          end
        end
        CLEAR: cnt <= '0;
        COMPUTE: begin
          if (cap) begin
            res       <= o_mat;
            cnt       <= '0;
            k         <= '0;
            m_valid_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!m_valid_q) begin
            m_valid_q <= 1'b1;
          end else if (m_fire) begin
            k <= k + 2'd1;
            if (k == 2'd3) m_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_controller.sv
// Self-checking bench for conv_stream_controller.
// Job-level model: streamed bytes map to matrices, o_mat bytes to output order.
module tb_conv_stream_controller;

  localparam int CC = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] i_mat;
  logic [71:0]  f_mat;
  logic         arr_clr;
  logic [31:0]  o_mat;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         m_ready;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  conv_stream_controller #(
    .DATA_W(8),
    .COMPUTE_CYCLES(CC),
    .CNT_W(5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .i_mat  (i_mat),
    .f_mat  (f_mat),
    .arr_clr(arr_clr),
    .o_mat  (o_mat),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]   bytes [25];
  logic [127:0] exp_i;
  logic [71:0]  exp_f;

  task automatic make_bytes(input bit seq);
    exp_i = '0;
    exp_f = '0;
    for (int j = 0; j < 25; j++) begin
      bytes[j] = seq ? 8'(j + 1) : 8'($urandom);
      if (j < 16) exp_i[8*j +: 8] = bytes[j];
      else        exp_f[8*(j-16) +: 8] = bytes[j];
    end
  endtask

  // in_mode: 0 continuous, 1 toggling, 2 random gaps
  task automatic send(input int in_mode);
    int idx = 0;
    int g = 0;
    bit x;
    while (idx < 25 && g < 1000) begin
      s_data = bytes[idx];
      unique case (in_mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (g % 2 == 0);
        default: s_valid = ($urandom % 3 != 0);
      endcase
      if (g == 0) chk("load_s_ready", s_ready, 1);
      chk("load_no_clr", arr_clr, 0);
      x = s_valid && s_ready;
      step();
      if (x) idx++;
      g++;
    end
    s_valid = 1'b0;
    if (idx < 25) chk("load_timeout", idx, 25);
  endtask

  // out_mode: 0 always ready, 1 five-cycle stall at k=1, 2 random
  task automatic run_job(input int in_mode, input int out_mode,
                         input bit seq, input logic [31:0] res);
    int c;
    int idx;
    int stall;
    int g;
    logic [7:0] exp_o [4];
    make_bytes(seq);
    o_mat = res;
    for (int j = 0; j < 4; j++) exp_o[j] = res[8*j +: 8];
    send(in_mode);
    chk("clr_pulse", arr_clr, 1);
    chk("clr_s_ready", s_ready, 0);
    chk("clr_busy", busy, 1);
    chk("i_mat", i_mat, exp_i);
    chk("f_mat", f_mat, exp_f);
    if (seq) begin
      chk("i00", i_mat[7:0], 8'd1);
      chk("i33", i_mat[127:120], 8'd16);
      chk("f00", f_mat[7:0], 8'd17);
      chk("f22", f_mat[71:64], 8'd25);
    end
    step();
    chk("clr_single", arr_clr, 0);
    c = 0;
    while (!m_valid && c < 200) begin
      chk("compute_busy", busy, 1);
      step();
      c++;
    end
    chk("m_valid_latency", c, CC + 1);
    // result must be latched, not passed through
    o_mat = ~res;
    idx = 0;
    stall = 0;
    g = 0;
    while (idx < 4 && g < 400) begin
      chk("m_valid", m_valid, 1);
      chk("m_data", m_data, exp_o[idx]);
      chk("hold_i_mat", i_mat, exp_i);
      if (out_mode == 1 && idx == 1 && stall < 5) begin
        m_ready = 1'b0;
        stall++;
      end else if (out_mode == 2) begin
        m_ready = ($urandom % 3 != 0);
      end else begin
        m_ready = 1'b1;
      end
      step();
      if (m_ready) idx++;
      g++;
    end
    m_ready = 1'b0;
    chk("drain_count", idx, 4);
    if (out_mode == 1) chk("stall_cycles", stall, 5);
    chk("post_s_ready", s_ready, 1);
    chk("post_m_valid", m_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  task automatic abort_job();
    make_bytes(1'b0);
    o_mat = 32'($urandom);
    send(0);
    for (int j = 0; j < 6; j++) step();
    chk("abort_busy_pre", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_arr_clr", arr_clr, 0);
    chk("rst_i_mat", i_mat, 0);
    chk("rst_f_mat", f_mat, 0);
    chk("rst_s_ready", s_ready, 0);
    #3;
    rst = 1'b1;
    step();
    chk("rst_release_s_ready", s_ready, 1);
    for (int j = 0; j < CC + 5; j++) begin
      chk("abort_no_m_valid", m_valid, 0);
      step();
    end
  endtask

  initial begin
    rst     = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    o_mat   = '0;
    #2;
    chk("reset_s_ready", s_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_arr_clr", arr_clr, 0);
    chk("reset_i_mat", i_mat, 0);
    chk("reset_f_mat", f_mat, 0);
    step();
    #3;
    rst = 1'b1;
    step();
    chk("idle_s_ready", s_ready, 1);

    run_job(0, 0, 1'b1, 32'h44_33_22_11);
    run_job(1, 1, 1'b1, 32'h44_33_22_11);
    run_job(0, 0, 1'b0, 32'($urandom));
    run_job(2, 2, 1'b0, 32'($urandom));
    abort_job();
    for (int j = 0; j < 4; j++)
      run_job(2, 2, 1'b0, 32'($urandom));
    run_job(0, 1, 1'b0, 32'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
